seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
Observes a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and reconstructs the hex value shown on each digit. It is the inverse of the team's hex-to-7-segment encoder and uses the same segment code table. It sits on the display bus as a checker/readback block. It requires each scan slot to be stable before accepting it, and flags patterns that are not legal digits.

Parameters:
NDIG, 8, number of digits on the bus (must be at least 2); the index width is IW = clog2(NDIG).
STABLE_CYC, 4, number of consecutive identical samples needed before a slot is accepted (must be at least 1); the counter width is derived from it.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
seg_n  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
an_n  input  NDIG  digit selects, active-low; bit i selects digit i
digits  output  4*NDIG  decoded values; nibble i is digits[4i+3:4i]
dig_valid  output  NDIG  bit i = 1 means nibble i holds a legal decoded value
dig_err  output  NDIG  bit i = 1 means the last accepted pattern for digit i was illegal
upd  output  1  one-cycle pulse, high for exactly one cycle on each accepted slot
upd_idx  output  IW  index of the digit accepted; meaningful only while upd=1

Behaviour:
- Input stage: seg_n and an_n are registered into s_seg and s_an. These reset to 7'h7F and all-ones.
- A slot is legal-select when exactly one bit of s_an is 0. The slot index is the position of that 0.
- A sample equals the previous one when both s_seg and s_an match the prior cycle.
- FSM has three states: IDLE, TRACK, LOCKED. Reset state is IDLE with cnt=0.
  - IDLE: when s_an is legal-select, go to TRACK with cnt=1. Otherwise stay.
  - TRACK:
    - s_an not legal-select: go to IDLE with cnt=0.
    - Sample differs from the previous one: stay in TRACK with cnt=1.
    - Sample equal and cnt < STABLE_CYC: increment cnt.
    - When cnt reaches STABLE_CYC: accept and go to LOCKED.
  - LOCKED: no further accepts. Any change in the sample goes to TRACK with cnt=1, or to IDLE if s_an is not legal-select.
- Latency:
  - Inputs held constant from just before edge 1 through edge STABLE_CYC are captured at edges 1..STABLE_CYC.
  - digits, dig_valid, dig_err, upd and upd_idx change at edge STABLE_CYC+1.
  - With STABLE_CYC=1, outputs change at edge 2.
- Accept action, for index k:
  - Legal code: nibble k = value, dig_valid[k]=1, dig_err[k]=0.
  - Blank (seg_n = 7'b1111111): dig_valid[k]=0, dig_err[k]=0, nibble k unchanged.
  - Any other pattern: dig_err[k]=1, dig_valid[k]=0, nibble k unchanged.
  - In all three cases: upd=1 for one cycle, upd_idx=k.
- Legal codes (seg_n, MSB first):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Decoding is a full 7-bit compare. 6 and b differ only in bit6 and must decode distinctly.
- Reset values:
  - digits=0, dig_valid=0, dig_err=0, upd=0, upd_idx=0.
  - FSM=IDLE, cnt=0, input stage at its idle values.
- Reset has priority. If rst=1 on an edge where an accept would occur, no upd is produced and all outputs clear.
- Reset mid-TRACK discards the count. After rst falls, a full STABLE_CYC window is required again.
- Boundary conditions:
  - Multiple anodes low, or none low: never accepted; treated as IDLE.
  - Anode changes while segments are constant: treated as a change; restart at cnt=1.
  - Slot held indefinitely: exactly one upd for it.
  - The same slot reappearing after any intervening change is accepted again, producing a fresh upd even if the value is identical.
  - cnt saturates; it never wraps.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0 and no upd during or after reset, until a valid window completes.
- Basic accept (STABLE_CYC=4): an_n=8'b1111_1110, seg_n=7'b0000110 held 20 cycles -> at edge 5, digits[3:0]=4'h3, dig_valid=8'h01, upd high 1 cycle with upd_idx=0; no further upd.
- Glitch rejection: an_n=8'b1101_1111, seg_n=0001000 held 3 edges, then seg_n=0000000 held 4 edges -> no upd for the first pattern; a single upd with upd_idx=5 and digits[23:20]=4'h8 at the 5th edge counted from the first capture of 0000000.
- Illegal/blank: digit 2 first accepted as A (0001000); then apply 1111110 on digit 2 -> dig_err[2]=1, dig_valid[2]=0, digits[11:8]=4'hA retained; then apply 1111111 -> dig_err[2]=0, dig_valid[2]=0, upd pulses each time.
- Bad select and reset priority: an_n=8'b1111_1100 held 10 cycles -> no upd. Then assert rst exactly on the accept edge of a legal window -> no upd, all outputs 0.
- Full sweep: scan 8 digits round-robin, each slot held 6 cycles, covering all 16 codes (including 6=0100000 vs b=1100000) -> every slot produces one upd, final digits and dig_valid=8'hFF match the reference model exactly.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Readback of a multiplexed active-low 7-segment bus. Each scan slot must be
// stable for STABLE_CYC samples before it is decoded into its digit's nibble.
module seg7_scan_decoder #(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4,
    localparam int IW        = $clog2(NDIG),
    localparam int CW        = $clog2(STABLE_CYC + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   an_n,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   dig_valid,
    output logic [NDIG-1:0]   dig_err,
    output logic              upd,
    output logic [IW-1:0]     upd_idx
);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

    // Same table as the encoder; a full 7-bit compare keeps 6 and b distinct.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    logic [6:0]        s_seg_q, p_seg_q;
    logic [NDIG-1:0]   s_an_q, p_an_q;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic              upd_q, upd_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic [NDIG-1:0]   sel;
    logic              sel_ok;
    logic              same;
    logic [IW-1:0]     sel_idx;
    logic              accept;
    logic [4:0]        dec;

    // Exactly one anode low: the inverted select is a nonzero power of two.
    assign sel    = ~s_an_q;
    assign sel_ok = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign same   = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);
    assign dec    = decode(s_seg_q);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel[i]) sel_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg_q <= 7'h7F;
            s_an_q  <= '1;
            p_seg_q <= 7'h7F;
            p_an_q  <= '1;
        end else begin
            s_seg_q <= seg_n;
            s_an_q  <= an_n;
            p_seg_q <= s_seg_q;
            p_an_q  <= s_an_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    state_d = TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            TRACK: begin
                if (!sel_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LOCKED: begin
                if (!sel_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Accept on the edge the count reaches its target so the outputs land
        // one edge after the last qualifying sample is captured.
        if (state_d == TRACK && cnt_d == CNT_MAX) begin
            state_d = LOCKED;
            accept  = 1'b1;
        end
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = err_q;
        upd_d    = 1'b0;
        idx_d    = idx_q;
        if (accept) begin
            upd_d = 1'b1;
            idx_d = sel_idx;
            if (dec[4]) begin
                digits_d[4*sel_idx +: 4] = dec[3:0];
                valid_d[sel_idx]         = 1'b1;
                err_d[sel_idx]           = 1'b0;
            end else if (s_seg_q == 7'h7F) begin
                valid_d[sel_idx] = 1'b0;
                err_d[sel_idx]   = 1'b0;
            end else begin
                valid_d[sel_idx] = 1'b0;
                err_d[sel_idx]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            upd_q    <= upd_d;
            idx_q    <= idx_d;
        end
    end

    assign digits    = digits_q;
    assign dig_valid = valid_q;
    assign dig_err   = err_q;
    assign upd       = upd_q;
    assign upd_idx   = idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scenarios plus random bus traffic, checked every cycle against a
// run-length reference model of the display readback.
module tb_seg7_scan_decoder;

    localparam int NDIG = 8;
    localparam int S    = 4;
    localparam int IW   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        seg_n;
    logic [NDIG-1:0]   an_n;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dig_valid;
    logic [NDIG-1:0]   dig_err;
    logic              upd;
    logic [IW-1:0]     upd_idx;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .digits(digits), .dig_valid(dig_valid), .dig_err(dig_err),
        .upd(upd), .upd_idx(upd_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_upd = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [6:0] codes [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference state: run length of identical captured samples.
    logic [6:0]        m_last_seg;
    logic [NDIG-1:0]   m_last_an;
    int                m_run;
    bit                m_pend;
    int                m_pidx;
    logic [6:0]        m_pseg;
    logic [4*NDIG-1:0] m_dig;
    logic [NDIG-1:0]   m_val, m_err;
    bit                m_upd;
    int                m_idx;

    function automatic int code_val(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    function automatic int sel_of(input logic [NDIG-1:0] a);
        int n = 0, p = -1;
        for (int i = 0; i < NDIG; i++) if (!a[i]) begin n++; p = i; end
        return (n == 1) ? p : -1;
    endfunction

    task automatic model_clear();
        m_last_seg = 7'h7F; m_last_an = '1; m_run = 0; m_pend = 0;
        m_dig = '0; m_val = '0; m_err = '0; m_upd = 0; m_idx = 0; m_pidx = 0;
        m_pseg = 7'h7F;
    endtask

    task automatic step(input logic [6:0] s, input logic [NDIG-1:0] a, input logic r);
        int v, k;
        seg_n = s; an_n = a; rst = r;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            m_upd = 0;
            if (m_pend) begin
                v = code_val(m_pseg);
                if (v >= 0) begin
                    m_dig[4*m_pidx +: 4] = 4'(v);
                    m_val[m_pidx] = 1'b1; m_err[m_pidx] = 1'b0;
                end else if (m_pseg == 7'h7F) begin
                    m_val[m_pidx] = 1'b0; m_err[m_pidx] = 1'b0;
                end else begin
                    m_val[m_pidx] = 1'b0; m_err[m_pidx] = 1'b1;
                end
                m_upd = 1; m_idx = m_pidx; m_pend = 0;
            end
            if (s == m_last_seg && a == m_last_an) begin
                if (m_run <= S) m_run++;
            end else begin
                m_run = 1;
            end
            m_last_seg = s; m_last_an = a;
            k = sel_of(a);
            if (k >= 0 && m_run == S) begin
                m_pend = 1; m_pidx = k; m_pseg = s;
            end
        end
        #1;
        if (upd) n_upd++;
        chk("upd", 64'(upd), 64'(m_upd));
        if (m_upd) chk("upd_idx", 64'(upd_idx), 64'(m_idx));
        chk("digits", 64'(digits), 64'(m_dig));
        chk("dig_valid", 64'(dig_valid), 64'(m_val));
        chk("dig_err", 64'(dig_err), 64'(m_err));
    endtask

    task automatic hold(input logic [6:0] s, input logic [NDIG-1:0] a, input int n);
        for (int i = 0; i < n; i++) step(s, a, 1'b0);
    endtask

    initial begin
        int u0, k, len;
        logic [6:0] s;
        logic [NDIG-1:0] a;
        model_clear();
        seg_n = '0; an_n = '1; rst = 1'b1;

        // Reset with random inputs
        step(7'($urandom), NDIG'($urandom), 1'b1);
        step(7'($urandom), NDIG'($urandom), 1'b1);
        chk("reset_outputs", {upd, dig_err, dig_valid, digits}, '0);

        // Basic accept: digit 0 shows 3
        u0 = n_upd;
        hold(7'b0000110, 8'b1111_1110, 4);
        chk("basic_no_early_upd", 64'(n_upd - u0), 64'd0);
        step(7'b0000110, 8'b1111_1110, 1'b0);
        chk("basic_upd_edge5", 64'(upd), 64'd1);
        chk("basic_nibble", 64'(digits[3:0]), 64'h3);
        chk("basic_valid", 64'(dig_valid), 64'h01);
        hold(7'b0000110, 8'b1111_1110, 15);
        chk("basic_single_upd", 64'(n_upd - u0), 64'd1);

        // Glitch rejection on digit 5
        u0 = n_upd;
        hold(7'b0001000, 8'b1101_1111, 3);
        hold(7'b0000000, 8'b1101_1111, 4);
        chk("glitch_none_yet", 64'(n_upd - u0), 64'd0);
        step(7'b0000000, 8'b1101_1111, 1'b0);
        chk("glitch_upd", 64'(upd), 64'd1);
        chk("glitch_idx", 64'(upd_idx), 64'd5);
        chk("glitch_nibble", 64'(digits[23:20]), 64'h8);
        hold(7'b0000000, 8'b1101_1111, 3);
        chk("glitch_one_upd", 64'(n_upd - u0), 64'd1);

        // Illegal and blank on digit 2
        u0 = n_upd;
        hold(7'b0001000, 8'b1111_1011, 6);
        hold(7'b1111110, 8'b1111_1011, 6);
        chk("illegal_err", 64'(dig_err[2]), 64'd1);
        chk("illegal_valid", 64'(dig_valid[2]), 64'd0);
        chk("illegal_keep", 64'(digits[11:8]), 64'hA);
        hold(7'b1111111, 8'b1111_1011, 6);
        chk("blank_err", 64'(dig_err[2]), 64'd0);
        chk("blank_valid", 64'(dig_valid[2]), 64'd0);
        chk("ill_blank_upds", 64'(n_upd - u0), 64'd3);

        // Two anodes low is never accepted
        u0 = n_upd;
        hold(7'b0000110, 8'b1111_1100, 10);
        chk("bad_select", 64'(n_upd - u0), 64'd0);

        // Reset lands exactly on the accept edge
        hold(7'b1001111, 8'b1110_1111, 4);
        step(7'b1001111, 8'b1110_1111, 1'b1);
        chk("rst_prio", {upd, dig_err, dig_valid, digits}, '0);
        u0 = n_upd;
        hold(7'b1001111, 8'b1110_1111, 4);
        chk("rst_restart_wait", 64'(n_upd - u0), 64'd0);
        step(7'b1001111, 8'b1110_1111, 1'b0);
        chk("rst_restart_upd", 64'(upd), 64'd1);

        // Full sweep: two rounds cover all 16 codes
        u0 = n_upd;
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < NDIG; d++) begin
                a = '1; a[d] = 1'b0;
                hold(codes[r*8 + d], a, 6);
            end
        step(7'h7F, '1, 1'b0);
        chk("sweep_upds", 64'(n_upd - u0), 64'd16);
        chk("sweep_digits", 64'(digits), 64'hFEDCBA98);
        chk("sweep_valid", 64'(dig_valid), 64'hFF);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            if (k < 6)       s = codes[$urandom_range(0, 15)];
            else if (k < 7)  s = 7'h7F;
            else             s = 7'($urandom);
            a = '1;
            k = $urandom_range(0, 9);
            if (k < 7)       a[$urandom_range(0, NDIG-1)] = 1'b0;
            else if (k < 9)  a = NDIG'($urandom);
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++)
                step(s, a, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
